multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter N, default 4: slice width in bits, the width of one adder pass.
REQ-002 Parameter K, default 4: number of slices; operand width W = N*K; K >= 1.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port start  input  1: request to add; sampled every cycle.
REQ-006 Port a  input  W: operand A, unsigned or two's complement.
REQ-007 Port b  input  W: operand B.
REQ-008 Port cin  input  1: carry into bit 0.
REQ-009 Port busy  output  1: high while slices are being summed.
REQ-010 Port done  output  1: one-cycle pulse; s, co and ovf are valid.
REQ-011 Port s  output  W: registered sum.
REQ-012 Port co  output  1: registered carry out of bit W-1.
REQ-013 Port ovf  output  1: registered signed overflow flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL latch a, b and cin, clear s/co/ovf to 0, set slice index 0 and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-016 Each RUN cycle SHALL add slice idx of A and B (bits idx*N+N-1 .. idx*N) plus the carry register using one N-bit adder.
- Same cycle: write the slice result into s, load the slice carry-out into the carry register, increment idx.
REQ-017 RUN SHALL last exactly K cycles; after the slice with idx = K-1 the FSM SHALL go to DONE.
REQ-018 Timing: start accepted in cycle c -> busy=1 in cycles c+1 .. c+K -> done=1 in cycle c+K+1 only (latency K+1).
REQ-019 On entry to DONE, co SHALL equal the final carry register value.
REQ-020 On entry to DONE, ovf SHALL equal (A[W-1] == B[W-1]) AND (s[W-1] != A[W-1]), using the latched operands.
REQ-021 DONE with start=1 SHALL accept a new operation exactly as IDLE does (back-to-back runs); DONE with start=0 SHALL go to IDLE.
REQ-022 start in RUN SHALL be ignored: no latch, no queueing, no effect on the current result.
REQ-023 a, b and cin SHALL affect the result only in the accept cycle; later input changes are ignored.
REQ-024 s, co and ovf SHALL hold their DONE values until the next accept or reset.
REQ-025 During RUN, s SHALL show partial results: only slices below idx are valid, the rest read 0.
REQ-026 The carry SHALL propagate between slices only through the carry register, never combinationally across cycles.
REQ-027 Wrap-around: the sum SHALL be modulo 2^W, with overflow reported only through co and ovf.
REQ-028 K=1 SHALL behave identically with a single RUN cycle (latency 2).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, idx=0, carry register 0, busy=0, done=0, s=0, co=0, ovf=0.
REQ-030 rst SHALL take priority over start and over any state, including mid-RUN.
- After an aborted run, no done pulse SHALL occur.
REQ-031 The first cycle after rst deasserts SHALL be able to accept start.

Structure
REQ-032 A shared package SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default N and K constants.
REQ-033 The block SHALL instantiate exactly one sub-module, nbit_adder (N-bit ripple-carry adder), as the sole arithmetic resource.
REQ-034 No other adder SHALL be inferred for the sum; the index counter may use its own increment.

Verification (N=4, K=4, W=16)
REQ-035 a=16'h00FF, b=16'h0001, cin=0, start in cycle c -> done in c+5 only; s=16'h0100, co=0, ovf=0.
REQ-036 a=16'hFFFF, b=16'h0001, cin=0 -> s=16'h0000, co=1, ovf=0.
REQ-037 a=16'h7FFF, b=16'h0001 -> s=16'h8000, co=0, ovf=1.
- a=16'h8000, b=16'h8000 -> s=0, co=1, ovf=1.
REQ-038 a=0, b=0, cin=1 -> s=16'h0001.
- Then start held high in all RUN cycles, with a and b changed -> result unchanged; second run begins only from the DONE cycle.
REQ-039 rst=1 in the second RUN cycle -> next cycle IDLE with busy=0, s=0, no done pulse.
- New start one cycle later -> correct result 5 cycles after it.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word sequential adder.
// Contents:
//   state_t   - controller states (IDLE, RUN, DONE)
//   DEFAULT_N - default slice width in bits
//   DEFAULT_K - default number of slices per operand
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_K = 4;

endpackage

// File: rtl/nbit_adder.sv
// N-bit ripple-carry adder, the only arithmetic unit of the sequential adder.
// Ports:
//   a, b : N-bit addends
//   ci   : carry into bit 0
//   s    : N-bit sum
//   co   : carry out of bit N-1
module nbit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    assign c[0] = ci;

    // One full adder per bit, carry rippling from bit 0 upward.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: adds two W = N*K bit operands one N-bit slice
// per clock using a single nbit_adder, carrying between slices in a register.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : request a new addition (accepted in IDLE or DONE)
//   a, b  : W-bit operands, captured only in the accept cycle
//   cin   : carry into bit 0, captured only in the accept cycle
//   busy  : high during the K slice cycles
//   done  : one-cycle pulse, s/co/ovf hold the finished result
//   s     : registered sum (partial while busy, upper slices read 0)
//   co    : registered carry out of bit W-1
//   ovf   : registered two's complement overflow flag
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int K = DEFAULT_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [N*K-1:0] s,
    output logic           co,
    output logic           ovf
);

    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last_slice;
    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_co;

    assign slice_a    = a_r[idx*N +: N];
    assign slice_b    = b_r[idx*N +: N];
    assign last_slice = (idx == IW'(K - 1));

    nbit_adder #(
        .N (N)
    ) u_adder (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE behaves like IDLE for a new start, which gives back-to-back runs;
    // start seen while in RUN is simply not decoded.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are held in a_r/b_r so later input changes cannot disturb a run.
    // On the last slice the new top bit of s is slice_sum[N-1], so the overflow
    // flag is formed from it directly rather than from the not-yet-updated s.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == RUN) begin
            s[idx*N +: N] <= slice_sum;
            carry         <= slice_co;
            idx           <= idx + IW'(1);
            if (last_slice) begin
                co  <= slice_co;
                ovf <= (a_r[W-1] == b_r[W-1]) && (slice_sum[N-1] != a_r[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=4, K=4, W=16).
// Expected results come from plain W+1 bit arithmetic on the operands.
module tb_multiword_add_seq;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(
        .N (N),
        .K (K)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge, away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] refSum(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic cv);
        return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
    endfunction

    function automatic logic refOvf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic cv);
        logic [W:0] full;
        full = refSum(av, bv, cv);
        return (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    endfunction

    // After j slices only the low j*N bits of the true sum are visible.
    function automatic logic [W-1:0] refPartial(input logic [W-1:0] av, input logic [W-1:0] bv,
                                                input logic cv, input int j);
        logic [W:0] mask;
        logic [W:0] masked;
        mask   = ((W+1)'(1) << (j * N)) - (W+1)'(1);
        masked = refSum(av, bv, cv) & mask;
        return masked[W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Start one operation and follow it cycle by cycle to its done pulse.
    // Returns in the DONE cycle with start left at holdStart.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                                 input bit holdStart, input bit scramble, input string tag);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = holdStart;
        for (int j = 0; j < K; j++) begin
            checkFlag({tag, " busy"}, busy, 1'b1);
            checkFlag({tag, " early done"}, done, 1'b0);
            checkOutput({tag, " partial s"}, s, refPartial(av, bv, cv, j));
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            tick();
        end
        begin
            logic [W:0] full;
            full = refSum(av, bv, cv);
            checkFlag({tag, " done"}, done, 1'b1);
            checkFlag({tag, " busy at done"}, busy, 1'b0);
            checkOutput({tag, " sum"}, s, full[W-1:0]);
            checkFlag({tag, " co"}, co, full[W]);
            checkFlag({tag, " ovf"}, ovf, refOvf(av, bv, cv));
        end
    endtask

    // Drop start after a done cycle and confirm the result is held in IDLE.
    task automatic idleCheck(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                             input string tag);
        logic [W:0] full;
        full  = refSum(av, bv, cv);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        tick();
        checkFlag({tag, " idle done"}, done, 1'b0);
        checkFlag({tag, " idle busy"}, busy, 1'b0);
        checkOutput({tag, " held sum"}, s, full[W-1:0]);
        checkFlag({tag, " held co"}, co, full[W]);
        checkFlag({tag, " held ovf"}, ovf, refOvf(av, bv, cv));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] prevA;
        logic [W-1:0] prevB;
        logic         prevC;
        bit           hold;

        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h4321;
        cin   = 1'b1;
        tick();
        tick();
        checkFlag("reset busy", busy, 1'b0);
        checkFlag("reset done", done, 1'b0);
        checkOutput("reset s", s, 16'h0000);
        checkFlag("reset co", co, 1'b0);
        checkFlag("reset ovf", ovf, 1'b0);

        // Start in the very first cycle after reset is released.
        rst = 1'b0;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "carry ripple");
        idleCheck(16'h00FF, 16'h0001, 1'b0, "carry ripple");

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "wrap");
        idleCheck(16'hFFFF, 16'h0001, 1'b0, "wrap");

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "pos ovf");
        idleCheck(16'h7FFF, 16'h0001, 1'b0, "pos ovf");

        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, "neg ovf");
        idleCheck(16'h8000, 16'h8000, 1'b0, "neg ovf");

        // Start held through RUN with inputs changing, then a new run from DONE.
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, "cin only");
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0, "back to back");
        idleCheck(16'hA5A5, 16'h5A5A, 1'b1, "back to back");

        // Reset in the second RUN cycle aborts the run without a done pulse.
        a     = 16'h1234;
        b     = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkFlag("abort busy", busy, 1'b0);
        checkFlag("abort done", done, 1'b0);
        checkOutput("abort s", s, 16'h0000);
        checkFlag("abort co", co, 1'b0);
        checkFlag("abort ovf", ovf, 1'b0);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, "after abort");
        idleCheck(16'h0F0F, 16'h00F1, 1'b0, "after abort");

        // Randomised runs, some chained back to back from the DONE cycle.
        prevA = '0;
        prevB = '0;
        prevC = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            hold = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, hold, 1'($urandom_range(0, 1)), "random");
            prevA = ra;
            prevB = rb;
            prevC = rc;
            if (!hold) begin
                idleCheck(prevA, prevB, prevC, "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
